// File: rtl/hazard3_instr_aligner_pkg.sv
// Shared constants for the instruction aligner and its halfword buffer.
// Sizes of the halfword queue and the 32-bit detection helper.
package hazard3_instr_aligner_pkg;

    localparam int HW_BUF_DEPTH = 4;
    localparam int HW_DATA_W    = 16;
    localparam int HW_ENTRY_W   = HW_DATA_W + 1;
    localparam int HW_LEVEL_W   = 3;

    function automatic logic hw_is_32bit(input logic [HW_DATA_W-1:0] hw);
        return hw[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/hazard3_instr_aligner_if.sv
// Fetch-side and decode-side signals of the instruction aligner.
// master = frontend/decode environment, slave = aligner.
interface hazard3_instr_aligner_if;

    logic [31:0] fetch_data;
    logic        fetch_vld;
    logic        fetch_rdy;
    logic        fetch_err;
    logic        jump_vld;
    logic [31:0] jump_target;
    logic [31:0] instr_out;
    logic        instr_vld;
    logic        instr_rdy;
    logic        instr_is_32bit;
    logic        instr_err;
    logic [31:0] instr_pc;

    modport master (
        output fetch_data,
        output fetch_vld,
        input  fetch_rdy,
        output fetch_err,
        output jump_vld,
        output jump_target,
        input  instr_out,
        input  instr_vld,
        output instr_rdy,
        input  instr_is_32bit,
        input  instr_err,
        input  instr_pc
    );

    modport slave (
        input  fetch_data,
        input  fetch_vld,
        output fetch_rdy,
        input  fetch_err,
        input  jump_vld,
        input  jump_target,
        output instr_out,
        output instr_vld,
        input  instr_rdy,
        output instr_is_32bit,
        output instr_err,
        output instr_pc
    );

endinterface

// File: rtl/hazard3_hw_shiftbuf.sv
// Halfword shift buffer: pop 0/1/2 from the head, push 0/1/2 at the tail.
// Pushed entries land after whatever survives the pop in the same cycle.
module hazard3_hw_shiftbuf
    import hazard3_instr_aligner_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [1:0]                         push_cnt,
    input  logic [2*HW_ENTRY_W-1:0]            push_data,
    input  logic [1:0]                         pop_cnt,
    output logic [HW_LEVEL_W-1:0]              level,
    output logic [HW_BUF_DEPTH*HW_ENTRY_W-1:0] entries
);

    logic [HW_ENTRY_W-1:0] mem     [HW_BUF_DEPTH];
    logic [HW_ENTRY_W-1:0] mem_nxt [HW_BUF_DEPTH];
    logic [HW_ENTRY_W-1:0] ext     [8];
    logic [HW_LEVEL_W-1:0] remain;
    logic [HW_LEVEL_W-1:0] level_nxt;
    logic [HW_ENTRY_W-1:0] push_lo;
    logic [HW_ENTRY_W-1:0] push_hi;

    assign push_lo = push_data[HW_ENTRY_W-1:0];
    assign push_hi = push_data[2*HW_ENTRY_W-1:HW_ENTRY_W];

    for (genvar g = 0; g < HW_BUF_DEPTH; g++) begin : g_flat
        assign entries[g*HW_ENTRY_W +: HW_ENTRY_W] = mem[g];
    end

    // Zero-extended view so head+pop indexing never leaves the array.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ext[i] = '0;
        end
        for (int i = 0; i < HW_BUF_DEPTH; i++) begin
            ext[i] = mem[i];
        end
    end

    // Shift out popped entries, then append pushed ones behind the survivors.
    always_comb begin
        remain    = level - {1'b0, pop_cnt};
        level_nxt = remain + {1'b0, push_cnt};
        for (int i = 0; i < HW_BUF_DEPTH; i++) begin
            mem_nxt[i] = mem[i];
            if (HW_LEVEL_W'(i) < remain) begin
                mem_nxt[i] = ext[HW_LEVEL_W'(i) + {1'b0, pop_cnt}];
            end else if (HW_LEVEL_W'(i) == remain && push_cnt != 2'd0) begin
                mem_nxt[i] = push_lo;
            end else if (HW_LEVEL_W'(i) == HW_LEVEL_W'(remain + 3'd1)
                         && push_cnt == 2'd2) begin
                mem_nxt[i] = push_hi;
            end
        end
    end

    // Storage and fill level; flush only empties, contents become stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < HW_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            level <= '0;
        end else begin
            level <= level_nxt;
            for (int i = 0; i < HW_BUF_DEPTH; i++) begin
                mem[i] <= mem_nxt[i];
            end
        end
    end

endmodule

// File: rtl/hazard3_instr_aligner.sv
// Turns aligned 32-bit fetch words into halfword-aligned 16/32-bit
// instructions with PC and error tag for the decompressor.
module hazard3_instr_aligner
    import hazard3_instr_aligner_pkg::*;
#(
    parameter bit          EXTENSION_C  = 1'b1,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input logic                     clk,
    input logic                     rst_n,
    hazard3_instr_aligner_if.slave  bus
);

    logic [HW_LEVEL_W-1:0]              level;
    logic [HW_BUF_DEPTH*HW_ENTRY_W-1:0] entries;
    logic [HW_ENTRY_W-1:0]              head;
    logic [HW_ENTRY_W-1:0]              second;
    logic [1:0]                         push_cnt;
    logic [2*HW_ENTRY_W-1:0]            push_data;
    logic [1:0]                         pop_cnt;
    logic                               skip_hw;
    logic [31:0]                        pc;
    logic                               is_32;
    logic                               have_two;
    logic                               vld;
    logic                               accept;
    logic                               consume;
    logic [HW_ENTRY_W-1:0]              fetch_lo;
    logic [HW_ENTRY_W-1:0]              fetch_hi;

    assign head     = entries[0 +: HW_ENTRY_W];
    assign second   = entries[HW_ENTRY_W +: HW_ENTRY_W];
    assign have_two = level >= 3'd2;

    assign fetch_lo = {bus.fetch_err, bus.fetch_data[15:0]};
    assign fetch_hi = {bus.fetch_err, bus.fetch_data[31:16]};

    // Length decode and presentation, from registered buffer state only.
    always_comb begin
        is_32 = (EXTENSION_C == 1'b0) || hw_is_32bit(head[HW_DATA_W-1:0]);
        // An erroring 32-bit head is released alone so a faulting fetch
        // cannot stall forever waiting for its second half.
        vld   = have_two
              || (level != '0 && (!is_32 || head[HW_ENTRY_W-1]));
    end

    // Handshakes; a jump discards any concurrent fetch beat or consume.
    always_comb begin
        accept  = bus.fetch_vld && bus.fetch_rdy && !bus.jump_vld;
        consume = vld && bus.instr_rdy && !bus.jump_vld;
        pop_cnt = 2'd0;
        if (consume) begin
            pop_cnt = (is_32 && have_two) ? 2'd2 : 2'd1;
        end
    end

    // Select halfwords to append; a pending skip drops the lower half.
    always_comb begin
        push_cnt  = 2'd0;
        push_data = '0;
        if (accept) begin
            if (skip_hw) begin
                push_cnt  = 2'd1;
                push_data = {{HW_ENTRY_W{1'b0}}, fetch_hi};
            end else begin
                push_cnt  = 2'd2;
                push_data = {fetch_hi, fetch_lo};
            end
        end
    end

    hazard3_hw_shiftbuf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.jump_vld),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .level     (level),
        .entries   (entries)
    );

    // PC and halfword-skip tracking; jump overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_VECTOR;
            skip_hw <= 1'b0;
        end else if (bus.jump_vld) begin
            pc      <= {bus.jump_target[31:1], 1'b0};
            skip_hw <= (EXTENSION_C != 1'b0) ? bus.jump_target[1] : 1'b0;
        end else begin
            if (consume) begin
                pc <= pc + (is_32 ? 32'd4 : 32'd2);
            end
            if (accept) begin
                skip_hw <= 1'b0;
            end
        end
    end

    // Output drive.
    always_comb begin
        bus.fetch_rdy      = level <= 3'd2;
        bus.instr_vld      = vld;
        bus.instr_is_32bit = is_32;
        bus.instr_out      = {second[HW_DATA_W-1:0], head[HW_DATA_W-1:0]};
        bus.instr_err      = head[HW_ENTRY_W-1]
                           || (is_32 && have_two && second[HW_ENTRY_W-1]);
        bus.instr_pc       = pc;
    end

endmodule

// File: tb/tb_hazard3_instr_aligner.sv
// Bench for hazard3_instr_aligner: table-driven fetch words feeding a
// scoreboard of expected instructions, plus jump/stall/error/reset sequences.
module tb_hazard3_instr_aligner;

    typedef struct packed {
        logic [31:0] instr;
        logic        is32;
        logic        err;
        logic        hi;
        logic [31:0] pc;
    } exp_t;

    typedef struct packed {
        logic [31:0] word;
        logic        ferr;
        logic [1:0]  n;
        exp_t        e0;
        exp_t        e1;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    hazard3_instr_aligner_if bus ();

    hazard3_instr_aligner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] instr, input logic is32,
                                input logic err, input logic hi,
                                input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.is32  = is32;
        e.err   = err;
        e.hi    = hi;
        e.pc    = pc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.instr_vld && bus.instr_rdy && !bus.jump_vld) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got %h pc %h want none",
                         bus.instr_out, bus.instr_pc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.hi) begin
                    chk("instr", bus.instr_out, mon_e.instr);
                end else begin
                    chk("instr16", {16'h0, bus.instr_out[15:0]},
                        {16'h0, mon_e.instr[15:0]});
                end
                chk("is32", {31'h0, bus.instr_is_32bit}, {31'h0, mon_e.is32});
                chk("err", {31'h0, bus.instr_err}, {31'h0, mon_e.err});
                chk("pc", bus.instr_pc, mon_e.pc);
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input logic e);
        bit ok;
        int n;
        bus.fetch_data = w;
        bus.fetch_err  = e;
        bus.fetch_vld  = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.fetch_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        bus.fetch_vld = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: got fetch_rdy=0 for %0d cycles want 1", n);
        end
    endtask

    task automatic jump(input logic [31:0] t);
        bus.jump_target = t;
        bus.jump_vld    = 1'b1;
        @(posedge clk);
        #1;
        bus.jump_vld    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        bus.fetch_data  = '0;
        bus.fetch_vld   = 1'b0;
        bus.fetch_err   = 1'b0;
        bus.jump_vld    = 1'b0;
        bus.jump_target = '0;
        bus.instr_rdy   = 1'b1;

        vecs[0] = '{32'h00A00093, 1'b0, 2'd1,
                    mk(32'h00A00093, 1, 0, 1, 32'h0), '0};
        vecs[1] = '{32'h00100113, 1'b0, 2'd1,
                    mk(32'h00100113, 1, 0, 1, 32'h4), '0};
        vecs[2] = '{32'h45014505, 1'b0, 2'd2,
                    mk(32'h4505, 0, 0, 0, 32'h8),
                    mk(32'h4501, 0, 0, 0, 32'hA)};
        vecs[3] = '{32'h00934505, 1'b0, 2'd1,
                    mk(32'h4505, 0, 0, 0, 32'hC), '0};
        vecs[4] = '{32'h12340000, 1'b0, 2'd2,
                    mk(32'h00000093, 1, 0, 1, 32'hE),
                    mk(32'h1234, 0, 0, 0, 32'h12)};
        vecs[5] = '{32'h00134505, 1'b0, 2'd1,
                    mk(32'h4505, 0, 0, 0, 32'h14), '0};
        vecs[6] = '{32'h45010000, 1'b1, 2'd2,
                    mk(32'h00000013, 1, 1, 1, 32'h16),
                    mk(32'h4501, 0, 1, 0, 32'h1A)};
        vecs[7] = '{32'h45014505, 1'b0, 2'd2,
                    mk(32'h4505, 0, 0, 0, 32'h1C),
                    mk(32'h4501, 0, 0, 0, 32'h1E)};

        @(negedge clk);
        chk("rst_fetch_rdy", {31'h0, bus.fetch_rdy}, 32'd1);
        chk("rst_instr_vld", {31'h0, bus.instr_vld}, 32'd0);
        chk("rst_instr_err", {31'h0, bus.instr_err}, 32'd0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back words, straddling and error tagging.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].n >= 2'd1) sb.push_back(vecs[i].e0);
            if (vecs[i].n == 2'd2) sb.push_back(vecs[i].e1);
            send_word(vecs[i].word, vecs[i].ferr);
        end
        drain();

        // Jump to upper halfword: skip pending, then a 32-bit head waits.
        jump(32'h0000_1002);
        @(negedge clk);
        chk("skip_vld", {31'h0, bus.instr_vld}, 32'd0);
        chk("jump_pc", bus.instr_pc, 32'h1002);
        @(posedge clk);
        #1;
        send_word(32'hABCF0001, 1'b0);
        repeat (3) @(negedge clk);
        chk("wait32_vld", {31'h0, bus.instr_vld}, 32'd0);
        chk("wait32_rdy", {31'h0, bus.fetch_rdy}, 32'd1);
        @(posedge clk);
        #1;
        sb.push_back(mk(32'h5678ABCF, 1, 0, 1, 32'h1002));
        sb.push_back(mk(32'h1234, 0, 0, 0, 32'h1006));
        send_word(32'h12345678, 1'b0);
        drain();

        // Lone erroring 32-bit halfword must not deadlock.
        jump(32'h0000_2002);
        sb.push_back(mk(32'hFFFF, 1, 1, 0, 32'h2002));
        send_word(32'hFFFF0000, 1'b1);
        drain();
        @(negedge clk);
        chk("lone_pc", bus.instr_pc, 32'h2006);
        @(posedge clk);
        #1;

        // Back-pressure: buffer fills to 4, then releases without loss.
        jump(32'h0000_3000);
        bus.instr_rdy = 1'b0;
        sb.push_back(mk(32'h00A00093, 1, 0, 1, 32'h3000));
        sb.push_back(mk(32'h00100113, 1, 0, 1, 32'h3004));
        sb.push_back(mk(32'h00200193, 1, 0, 1, 32'h3008));
        send_word(32'h00A00093, 1'b0);
        send_word(32'h00100113, 1'b0);
        @(negedge clk);
        chk("full_fetch_rdy", {31'h0, bus.fetch_rdy}, 32'd0);
        chk("full_instr_vld", {31'h0, bus.instr_vld}, 32'd1);
        @(posedge clk);
        #1;
        fork
            send_word(32'h00200193, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.instr_rdy = 1'b1;
            end
        join
        drain();

        // Asynchronous reset in the middle of buffered data.
        bus.instr_rdy = 1'b0;
        send_word(32'h45014505, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_fetch_rdy", {31'h0, bus.fetch_rdy}, 32'd1);
        chk("mrst_instr_vld", {31'h0, bus.instr_vld}, 32'd0);
        chk("mrst_instr_err", {31'h0, bus.instr_err}, 32'd0);
        chk("mrst_pc", bus.instr_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("end_queue", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
